mat_mult_loader: RTL and testbench
==================================

MAT_MULT_LOADER -- requirements
Module: mat_mult_loader

Interface
REQ-001 Parameter mat_num_row, default 4, matrix dimension N; each matrix is 2*N*N 64-bit words (AW = 2*N*N).
REQ-002 Parameter ADDR_W, default 23, width of the Avalon address.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a multiply job.
REQ-006 s_valid/s_ready/s_data  input/output/input  1/1/64  operand stream: AW words of A, then AW words of B.
REQ-007 m_address/m_writedata/m_write/m_read/m_byteenable  output  ADDR_W/64/1/1/8  Avalon-MM master to the multiplier wrapper.
REQ-008 m_readdata/m_waitrequest  input  64/1  wrapper read data and stall.
REQ-009 o_valid/o_ready/o_data/o_last  output/input/output/output  1/1/64/1  result stream, AW words of C.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle pulse after the last result word is accepted.

Function
REQ-012 FSM states: IDLE, ACCEPT, WR_LO, WR_HI, TRIG, WAIT_HI, WAIT_LO, READ; implementation SHALL use exactly these.
REQ-013 IDLE: start=1 -> ACCEPT, word index k=0, busy=1; start in any other state is ignored.
REQ-014 ACCEPT: s_ready=1; on s_valid, latch s_data, go WR_LO; s_ready=0 in all other states.
REQ-015 WR_LO: m_write=1, m_address=k, m_byteenable=8'h0F, m_writedata=latched word; advance to WR_HI when m_waitrequest=0, else hold all signals.
REQ-016 WR_HI: same with m_byteenable=8'hF0; on completion k+1; k=2*AW-1 -> TRIG, else ACCEPT.
REQ-017 Word k<AW lands in A[k], k>=AW in B[k-AW]; address is k unmodified.
REQ-018 TRIG: m_address=2*AW, m_write=1 for exactly one cycle, then WAIT_HI.
REQ-019 Outside TRIG, m_address SHALL never equal 2*AW; idle value is 0, with m_write=m_read=0 and m_byteenable=0.
REQ-020 WAIT_HI: wait for m_waitrequest=1, then WAIT_LO; WAIT_LO: wait for m_waitrequest=0, then READ with k=0.
REQ-021 READ: m_read=1, m_address=k whenever output register is empty or o_ready=1; m_readdata sampled the same cycle into o_data, o_valid=1, k+1.
REQ-022 Output register holds o_data/o_valid stable until o_ready=1; full throughput of one word per cycle under constant o_ready.
REQ-023 o_last=1 with the word k=AW-1; its acceptance returns to IDLE, pulses done, clears busy.
REQ-024 s_valid gaps and o_ready deassertion at any cycle SHALL neither lose nor duplicate words.

Reset
REQ-025 reset=0 asynchronously forces IDLE, k=0, all outputs 0 (s_ready, m_*, o_valid, o_data, o_last, busy, done).
REQ-026 Reset mid-job abandons the job; the system top drives the wrapper's active-high reset from the inverted reset so both restart together.
REQ-027 First start after reset release behaves as a fresh job.

Structure
REQ-028 Shared package mat_mult_pkg holds the FSM state enum, default N, word width 64, and byteenable constants BE_LO=8'h0F, BE_HI=8'hF0.
REQ-029 No sub-module; output register is inline (single-entry buffer).

Verification (N=4, AW=32, behavioural wrapper model)
REQ-030 Feed words value i for i=0..63 -> 128 writes: address i, BE 0F then F0, writedata=i; then one-cycle write to address 64.
REQ-031 Model holds m_waitrequest=1 for 3 cycles during WR_LO of k=5 -> address 5, data 5, BE 0F held stable, no skipped write.
REQ-032 Model waitrequest high 20 cycles after trigger, C[j]=j+100 -> 32 outputs 100..131 in order, o_last on 131, done one cycle after acceptance.
REQ-033 o_ready toggled pseudo-randomly, s_valid with gaps -> identical output sequence, no duplicates, m_address never 64 outside TRIG.
REQ-034 start pulsed during READ -> ignored; reset=0 mid-READ -> all outputs 0 immediately; new job completes correctly.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared definitions for the matrix-multiply loader.
//   - default matrix dimension, data word width, byteenable lane constants
//   - FSM state encoding used by mat_mult_loader
//   - helper returning the number of 64-bit words per matrix
package mat_mult_pkg;

  localparam int unsigned MAT_N_DEFAULT = 4;
  localparam int unsigned WORD_W        = 64;
  localparam int unsigned BE_W          = WORD_W / 8;

  // The wrapper takes each 64-bit operand as two 32-bit lane writes.
  localparam logic [BE_W-1:0] BE_LO = 8'h0F;
  localparam logic [BE_W-1:0] BE_HI = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WR_LO,
    WR_HI,
    TRIG,
    WAIT_HI,
    WAIT_LO,
    READ
  } state_e;

  // Words occupied by one N x N matrix in the wrapper's address map.
  function automatic int unsigned words_per_matrix(input int unsigned n);
    return 2 * n * n;
  endfunction

endpackage

// File: rtl/mat_mult_loader.sv
// Loader/unloader for an Avalon-MM matrix multiplier wrapper.
// Collects 2*AW operand words from a valid/ready stream, writes each one to
// the wrapper as a low-lane then a high-lane write at address k, pokes the
// trigger address 2*AW, waits for the wrapper's busy handshake on
// m_waitrequest (rise then fall), then reads AW result words out onto a
// valid/ready stream through a single-entry output register.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start                      one-cycle job request (honoured only when idle)
//   s_valid/s_ready/s_data     operand stream: A words then B words
//   m_address ... m_byteenable Avalon-MM master towards the wrapper
//   m_readdata, m_waitrequest  wrapper read data and stall
//   o_valid/o_ready/o_data/o_last  result stream, o_last on the final word
//   busy                       high from accepted start until done
//   done                       one-cycle pulse after the last word is taken
module mat_mult_loader
  import mat_mult_pkg::*;
#(
  parameter int unsigned mat_num_row = MAT_N_DEFAULT,
  parameter int unsigned ADDR_W      = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic [ADDR_W-1:0] m_address,
  output logic [WORD_W-1:0] m_writedata,
  output logic              m_write,
  output logic              m_read,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic [WORD_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned AW = words_per_matrix(mat_num_row);
  // k runs up to 2*AW on the write side, so it needs room for that value.
  localparam int unsigned KW = $clog2(2 * AW + 1);

  localparam logic [KW-1:0]     K_AW      = KW'(AW);
  localparam logic [KW-1:0]     K_AW_LAST = KW'(AW - 1);
  localparam logic [KW-1:0]     K_IN_LAST = KW'(2 * AW - 1);
  localparam logic [ADDR_W-1:0] TRIG_ADDR = ADDR_W'(2 * AW);

  state_e              state_q;
  logic [KW-1:0]       k_q;
  logic                s_ready_q;
  logic [ADDR_W-1:0]   m_address_q;
  logic [WORD_W-1:0]   m_writedata_q;
  logic                m_write_q;
  logic [BE_W-1:0]     m_byteenable_q;
  logic                o_valid_q;
  logic [WORD_W-1:0]   o_data_q;
  logic                o_last_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_fire;

  // A read is issued whenever the output register can take a word this
  // cycle; the wrapper answers combinationally, so the data is captured on
  // the same edge and the stream keeps one word per cycle under o_ready=1.
  assign rd_fire = (state_q == READ) && (k_q < K_AW) && (!o_valid_q || o_ready);

  assign s_ready      = s_ready_q;
  assign m_address    = rd_fire ? ADDR_W'(k_q) : m_address_q;
  assign m_writedata  = m_writedata_q;
  assign m_write      = m_write_q;
  assign m_read       = rd_fire;
  assign m_byteenable = m_byteenable_q;
  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_last       = o_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      k_q            <= '0;
      s_ready_q      <= 1'b0;
      m_address_q    <= '0;
      m_writedata_q  <= '0;
      m_write_q      <= 1'b0;
      m_byteenable_q <= '0;
      o_valid_q      <= 1'b0;
      o_data_q       <= '0;
      o_last_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ACCEPT;
            k_q       <= '0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
          end
        end

        ACCEPT: begin
          if (s_valid) begin
            state_q        <= WR_LO;
            s_ready_q      <= 1'b0;
            m_write_q      <= 1'b1;
            m_address_q    <= ADDR_W'(k_q);
            m_byteenable_q <= BE_LO;
            m_writedata_q  <= s_data;
          end
        end

        // Address and data stay put; only the lane select changes.
        WR_LO: begin
          if (!m_waitrequest) begin
            state_q        <= WR_HI;
            m_byteenable_q <= BE_HI;
          end
        end

        WR_HI: begin
          if (!m_waitrequest) begin
            k_q <= k_q + 1'b1;
            if (k_q == K_IN_LAST) begin
              state_q        <= TRIG;
              m_address_q    <= TRIG_ADDR;
              m_byteenable_q <= BE_LO | BE_HI;
            end else begin
              state_q        <= ACCEPT;
              s_ready_q      <= 1'b1;
              m_write_q      <= 1'b0;
              m_address_q    <= '0;
              m_byteenable_q <= '0;
              m_writedata_q  <= '0;
            end
          end
        end

        // The trigger write is a single-cycle strobe, not a stallable write.
        TRIG: begin
          state_q        <= WAIT_HI;
          m_write_q      <= 1'b0;
          m_address_q    <= '0;
          m_byteenable_q <= '0;
          m_writedata_q  <= '0;
        end

        // The wrapper signals "computing" by raising waitrequest and
        // "finished" by dropping it again.
        WAIT_HI: begin
          if (m_waitrequest) begin
            state_q <= WAIT_LO;
          end
        end

        WAIT_LO: begin
          if (!m_waitrequest) begin
            state_q <= READ;
            k_q     <= '0;
          end
        end

        READ: begin
          if (o_valid_q && o_ready) begin
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            if (o_last_q) begin
              state_q <= IDLE;
              k_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          // Never coincides with the final acceptance: k has reached AW.
          if (rd_fire) begin
            o_valid_q <= 1'b1;
            o_data_q  <= m_readdata;
            o_last_q  <= (k_q == K_AW_LAST);
            k_q       <= k_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_loader.sv
// Bench for mat_mult_loader: a behavioural wrapper/stream model checks every
// Avalon write, the trigger strobe, the result stream and the done pulse
// against expectations derived from the fed operand words.
module tb_mat_mult_loader;

  localparam int unsigned N      = 4;
  localparam int unsigned AW     = 2 * N * N;
  localparam int unsigned NW     = 2 * AW;
  localparam int unsigned ADDR_W = 23;

  logic              clk;
  logic              reset;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [63:0]       s_data;
  logic [ADDR_W-1:0] m_address;
  logic [63:0]       m_writedata;
  logic              m_write;
  logic              m_read;
  logic [7:0]        m_byteenable;
  logic [63:0]       m_readdata;
  logic              m_waitrequest;
  logic              o_valid;
  logic              o_ready;
  logic [63:0]       o_data;
  logic              o_last;
  logic              busy;
  logic              done;

  mat_mult_loader #(
    .mat_num_row(N),
    .ADDR_W     (ADDR_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_write      (m_write),
    .m_read       (m_read),
    .m_byteenable (m_byteenable),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap_pct;
    int ordy_pct;
    int trig_wait;
    int stall_k;
    int stall_n;
    int c_mode;
    int exp_writes;
    int exp_outs;
  } vec_t;

  vec_t vecs[4];

  int total;
  int bad;

  logic [63:0] fed[NW];
  logic [63:0] mem[NW];

  int model_en;
  int gap_pct, ordy_pct, trig_wait, stall_k, stall_left, c_mode;
  int wr_idx, feed_idx, out_idx, trig_cnt, trig_left;
  int hold_pending, expect_done, done_seen;
  logic [63:0] held;
  int rd_idx;

  // Wrapper read port: result C[j] is either j+100 or A[j]+B[j] as stored.
  always_comb begin
    m_readdata = '0;
    rd_idx = int'(m_address[4:0]);
    if (m_address < ADDR_W'(AW)) begin
      if (c_mode != 0) m_readdata = mem[rd_idx] + mem[rd_idx + int'(AW)];
      else             m_readdata = 64'(rd_idx) + 64'd100;
    end
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [94:0] exp_wr(input int idx);
    return {ADDR_W'(idx / 2), ((idx % 2) != 0) ? 8'hF0 : 8'h0F, fed[idx / 2]};
  endfunction

  function automatic logic [63:0] exp_c(input int j);
    if (c_mode != 0) return fed[j] + fed[j + int'(AW)];
    return 64'(j + 100);
  endfunction

  // Drives inputs on the falling edge, samples 3 ns later (just before the
  // rising edge) to see exactly what the DUT will act on.
  task automatic bus_loop();
    forever begin
      @(negedge clk);
      if (model_en == 0) begin
        m_waitrequest = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        o_ready = 1'b0;
        continue;
      end
      m_waitrequest = (trig_left > 0) ||
                      (stall_left > 0 && m_write && m_address == ADDR_W'(stall_k) &&
                       m_byteenable == 8'h0F);
      if (feed_idx < int'(NW) && int'($urandom_range(99)) >= gap_pct) begin
        s_valid = 1'b1;
        s_data = fed[feed_idx];
      end else begin
        s_valid = 1'b0;
        s_data = {$urandom, $urandom};
      end
      o_ready = int'($urandom_range(99)) < ordy_pct;
      #3;
      if (model_en == 0) continue;

      if (m_address == ADDR_W'(NW)) begin
        chk("trig_once", {m_write, trig_cnt == 0}, 2'b11);
        trig_cnt++;
      end
      if (m_waitrequest && trig_left > 0) trig_left--;
      if (m_write && m_waitrequest) begin
        chk("stall_hold", {m_address, m_byteenable, m_writedata}, exp_wr(wr_idx));
        if (stall_left > 0) stall_left--;
      end else if (m_write) begin
        if (wr_idx < int'(2 * NW)) begin
          chk("wr_seq", {m_address, m_byteenable, m_writedata}, exp_wr(wr_idx));
          if (m_byteenable == 8'h0F) mem[m_address[5:0]][31:0] = m_writedata[31:0];
          if (m_byteenable == 8'hF0) mem[m_address[5:0]][63:32] = m_writedata[63:32];
        end else if (wr_idx == int'(2 * NW)) begin
          chk("wr_trig_addr", m_address, ADDR_W'(NW));
          trig_left = trig_wait;
        end else begin
          chk("wr_extra", wr_idx, 2 * NW);
        end
        wr_idx++;
      end
      if (s_valid && s_ready) feed_idx++;

      if (expect_done != 0) begin
        chk("done_pulse", {done, busy}, 2'b10);
        expect_done = 0;
        done_seen = 1;
      end else if (done) begin
        chk("done_spurious", done, 1'b0);
      end
      if (hold_pending != 0) chk("o_hold", {o_valid, o_data}, {1'b1, held});
      if (o_valid && o_ready) begin
        if (out_idx < int'(AW))
          chk("o_data", {o_last, o_data}, {out_idx == int'(AW) - 1, exp_c(out_idx)});
        else
          chk("o_extra", out_idx, AW);
        if (o_last) expect_done = 1;
        out_idx++;
      end
      hold_pending = (o_valid && !o_ready) ? 1 : 0;
      held = o_data;
    end
  endtask

  task automatic launch_job(input vec_t v);
    @(posedge clk);
    #1;
    gap_pct = v.gap_pct;
    ordy_pct = v.ordy_pct;
    trig_wait = v.trig_wait;
    stall_k = v.stall_k;
    stall_left = v.stall_n;
    c_mode = v.c_mode;
    for (int i = 0; i < int'(NW); i++) begin
      fed[i] = (v.c_mode == 0) ? 64'(i) : {$urandom, $urandom};
      mem[i] = '0;
    end
    wr_idx = 0; feed_idx = 0; out_idx = 0; trig_cnt = 0; trig_left = 0;
    hold_pending = 0; expect_done = 0; done_seen = 0;
    model_en = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen == 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("job_done", done_seen, 1);
  endtask

  task automatic wait_outs(input int cnt);
    int n;
    n = 0;
    while (out_idx < cnt && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("reach_read", out_idx >= cnt, 1'b1);
  endtask

  task automatic end_checks(input vec_t v);
    chk("n_writes", wr_idx, v.exp_writes);
    chk("n_outs", out_idx, v.exp_outs);
    chk("n_trig", trig_cnt, 1);
    chk("n_fed", feed_idx, NW);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0;
    model_en = 0; c_mode = 0; gap_pct = 0; ordy_pct = 100; trig_wait = 1;
    stall_k = -1; stall_left = 0;
    wr_idx = 0; feed_idx = 0; out_idx = 0; trig_cnt = 0; trig_left = 0;
    hold_pending = 0; expect_done = 0; done_seen = 0; held = '0;
    m_waitrequest = 1'b0; s_valid = 1'b0; s_data = '0; o_ready = 1'b0;
    for (int i = 0; i < int'(NW); i++) begin
      fed[i] = '0;
      mem[i] = '0;
    end

    //        gap ordy trig stall_k n cmode writes      outs
    vecs[0] = '{0,  100, 20,  5,     3, 0, 2*NW+1, AW};
    vecs[1] = '{30, 50,  5,   -1,    0, 1, 2*NW+1, AW};
    vecs[2] = '{60, 20,  1,   63,    2, 1, 2*NW+1, AW};
    vecs[3] = '{10, 80,  3,   0,     5, 1, 2*NW+1, AW};

    fork
      bus_loop();
    join_none

    #2 reset = 1'b0;
    #10;
    chk("reset_outs", {s_ready, m_address, m_writedata, m_write, m_read, m_byteenable,
                       o_valid, o_data, o_last, busy, done}, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_rst", {busy, s_ready, done, o_valid, m_write, m_read}, '0);

    for (int i = 0; i < 4; i++) begin
      launch_job(vecs[i]);
      wait_done();
      end_checks(vecs[i]);
    end

    // start pulsed while results are streaming out must be ignored
    launch_job(vecs[1]);
    wait_outs(5);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    end_checks(vecs[1]);
    repeat (5) @(posedge clk);
    #1;
    chk("start_ignored", {busy, s_ready}, 2'b00);

    // reset in the middle of READ clears everything at once
    launch_job(vecs[2]);
    wait_outs(3);
    @(posedge clk);
    #2;
    model_en = 0;
    reset = 1'b0;
    #1;
    chk("rst_mid_read", {s_ready, m_address, m_writedata, m_write, m_read, m_byteenable,
                         o_valid, o_data, o_last, busy, done}, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    launch_job(vecs[0]);
    wait_done();
    end_checks(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
